// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller.
// Shows a mole on one of eight LEDs. A keypad hit on the matching key scores a
// point. Each round ends with a hit or miss feedback phase. After ROUNDS rounds
// the game parks in DONE until the next start pulse.
module mole_game_ctrl #(
    parameter int TICK_DIV    = 100000,
    parameter int SHOW_MS     = 1000,
    parameter int FEEDBACK_MS = 200,
    parameter int ROUNDS      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic [7:0] led,
    output logic       buzzer,
    output logic [4:0] score,
    output logic [4:0] round,
    output logic       busy,
    output logic       done
);

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX = (SHOW_MS > FEEDBACK_MS) ? SHOW_MS : FEEDBACK_MS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_MS - 1);
    localparam logic [TW-1:0] FB_LAST    = TW'(FEEDBACK_MS - 1);
    localparam logic [4:0]    ROUNDS_V   = 5'(ROUNDS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SHOW = 3'd1,
        HIT  = 3'd2,
        MISS = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [TW-1:0] tick;
    logic [7:0]    lfsr;
    logic [2:0]    target;

    logic          tick_wrap;
    logic          show_end;
    logic          fb_end;
    logic [2:0]    next_target;
    logic [7:0]    next_show_led;
    logic          key_hit;
    logic          key_miss;
    logic [4:0]    score_inc;
    logic [4:0]    round_inc;

    // Timer expiries are taken from the last cycle of the last tick. This makes
    // the dwell equal to ticks*TICK_DIV cycles exactly.
    assign tick_wrap = (presc == PRESC_LAST);
    assign show_end  = tick_wrap && (tick == SHOW_LAST);
    assign fb_end    = tick_wrap && (tick == FB_LAST);

    // The new target is bumped by one when the LFSR would repeat the previous mole.
    assign next_target   = (lfsr[2:0] == target) ? (lfsr[2:0] + 3'd1) : lfsr[2:0];
    assign next_show_led = 8'd1 << next_target;

    // Only keys 0..7 can cause a miss. Keys 8..15 and "no key" (16) are ignored.
    assign key_hit  = key_valid && (key_code == {2'b00, target});
    assign key_miss = key_valid && (key_code[4:3] == 2'b00) && !key_hit;

    // Counters saturate at ROUNDS rather than wrapping.
    assign score_inc = (score >= ROUNDS_V) ? score : score + 5'd1;
    assign round_inc = (round >= ROUNDS_V) ? round : round + 5'd1;

    // Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used as the target source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Game FSM with timers and registered outputs. Every transition clears the timers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            presc  <= '0;
            tick   <= '0;
            target <= 3'd0;
            led    <= 8'h00;
            buzzer <= 1'b0;
            score  <= 5'd0;
            round  <= 5'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (tick_wrap) begin
                presc <= '0;
                tick  <= tick + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            case (state)
                IDLE: begin
                    presc  <= '0;
                    tick   <= '0;
                    led    <= 8'h00;
                    buzzer <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    if (start) begin
                        state  <= SHOW;
                        score  <= 5'd0;
                        round  <= 5'd0;
                        target <= next_target;
                        led    <= next_show_led;
                        busy   <= 1'b1;
                    end
                end

                SHOW: begin
                    // A matching key wins over a coincident window expiry.
                    if (key_hit) begin
                        state  <= HIT;
                        score  <= score_inc;
                        led    <= 8'hFF;
                        buzzer <= 1'b1;
                        presc  <= '0;
                        tick   <= '0;
                    end else if (key_miss || show_end) begin
                        state  <= MISS;
                        led    <= 8'h00;
                        buzzer <= 1'b0;
                        presc  <= '0;
                        tick   <= '0;
                    end
                end

                HIT, MISS: begin
                    if (fb_end) begin
                        round  <= round_inc;
                        buzzer <= 1'b0;
                        presc  <= '0;
                        tick   <= '0;
                        if (round_inc == ROUNDS_V) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            led   <= (score == ROUNDS_V) ? 8'hFF : 8'h00;
                        end else begin
                            state  <= SHOW;
                            target <= next_target;
                            led    <= next_show_led;
                        end
                    end
                end

                DONE: begin
                    presc <= '0;
                    tick  <= '0;
                    if (start) begin
                        state  <= SHOW;
                        score  <= 5'd0;
                        round  <= 5'd0;
                        target <= next_target;
                        led    <= next_show_led;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    led    <= 8'h00;
                    buzzer <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Testbench for mole_game_ctrl.
// Runs directed game scenarios and then randomized games. Results are compared
// with a rule-level model of score, round, target choice and phase lengths.
module tb_mole_game_ctrl;

    localparam int TD       = 4;
    localparam int SM       = 3;
    localparam int FM       = 2;
    localparam int RN       = 4;
    localparam int SHOW_CYC = TD * SM;
    localparam int FB_CYC   = TD * FM;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start     = 1'b0;
    logic       key_valid = 1'b0;
    logic [4:0] key_code  = 5'd16;
    logic [7:0] led;
    logic       buzzer;
    logic [4:0] score;
    logic [4:0] round;
    logic       busy;
    logic       done;

    mole_game_ctrl #(
        .TICK_DIV   (TD),
        .SHOW_MS    (SM),
        .FEEDBACK_MS(FM),
        .ROUNDS     (RN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_valid(key_valid),
        .key_code (key_code),
        .led      (led),
        .buzzer   (buzzer),
        .score    (score),
        .round    (round),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [7:0] m_lfsr;
    logic [7:0] m_samp;          // LFSR value seen by the most recent clock edge
    int         m_tgt   = 0;
    int         m_score = 0;
    int         m_round = 0;
    logic [7:0] prev_show_led = 8'h01;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Target-source sequence: reset to the seed, then one step per clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 8'hA5;
            m_samp <= 8'hA5;
        end else begin
            m_samp <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called at the first sample after a SHOW entry edge
    task automatic show_entry_check();
        int t;
        t = int'(m_samp[2:0]);
        if (t == m_tgt) t = (t + 1) % 8;
        m_tgt = t;
        chk("show_led", {24'd0, led}, 32'(1 << m_tgt));
        chk("distinct", {31'd0, (led != prev_show_led)}, 32'd1);
        prev_show_led = led;
        chk("show_busy", {31'd0, busy}, 32'd1);
        chk("show_done", {31'd0, done}, 32'd0);
        chk("show_buzzer", {31'd0, buzzer}, 32'd0);
        chk("show_score", {27'd0, score}, 32'(m_score));
        chk("show_round", {27'd0, round}, 32'(m_round));
    endtask

    task automatic done_check();
        chk("done_flag", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_score", {27'd0, score}, 32'(m_score));
        chk("done_round", {27'd0, round}, 32'(RN));
        chk("done_led", {24'd0, led}, (m_score == RN) ? 32'hFF : 32'h00);
        chk("done_buzzer", {31'd0, buzzer}, 32'd0);
    endtask

    task automatic start_game();
        start = 1'b1;
        step();
        start = 1'b0;
        m_score = 0;
        m_round = 0;
        show_entry_check();
    endtask

    // Play one round from the first SHOW sample.
    // action: 0 = matching key, 1 = wrong key 0..7, 2 = ignored key 8..16,
    //         3 = no key, 4 = start pulse (ignored).
    // The stimulus is applied at SHOW cycle d, with d from 0 to SHOW_CYC-1.
    task automatic run_round(input int action, input int d);
        bit resolved;
        bit hit;
        resolved = 1'b0;
        hit      = 1'b0;
        for (int i = 0; i < SHOW_CYC && !resolved; i++) begin
            chk("show_hold", {24'd0, led}, 32'(1 << m_tgt));
            if (i == d && action != 3) begin
                if (action == 4) begin
                    start = 1'b1;
                end else begin
                    key_valid = 1'b1;
                    case (action)
                        0:       key_code = 5'(m_tgt);
                        1:       key_code = 5'((m_tgt + 1 + $urandom_range(0, 6)) % 8);
                        default: key_code = 5'($urandom_range(8, 16));
                    endcase
                end
                step();
                start     = 1'b0;
                key_valid = 1'b0;
                key_code  = 5'd16;
                if (action == 0) begin
                    resolved = 1'b1;
                    hit      = 1'b1;
                end else if (action == 1) begin
                    resolved = 1'b1;
                end
            end else begin
                step();
            end
        end
        if (hit && m_score < RN) m_score++;
        for (int i = 0; i < FB_CYC; i++) begin
            chk("fb_led", {24'd0, led}, hit ? 32'hFF : 32'h00);
            chk("fb_buzzer", {31'd0, buzzer}, {31'd0, hit});
            chk("fb_score", {27'd0, score}, 32'(m_score));
            chk("fb_round", {27'd0, round}, 32'(m_round));
            step();
        end
        if (m_round < RN) m_round++;
        if (m_round == RN) done_check();
        else show_entry_check();
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        chk("rst_led", {24'd0, led}, 32'h00);
        chk("rst_buzzer", {31'd0, buzzer}, 32'd0);
        chk("rst_score", {27'd0, score}, 32'd0);
        chk("rst_round", {27'd0, round}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        // A key pulse in IDLE is ignored
        key_valid = 1'b1;
        key_code  = 5'd0;
        step();
        key_valid = 1'b0;
        key_code  = 5'd16;
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_led", {24'd0, led}, 32'h00);

        // Game 1: timeout, hit, wrong key, ignored key then timeout
        start_game();
        run_round(3, 0);
        run_round(0, int'($urandom_range(0, SHOW_CYC - 1)));
        run_round(1, int'($urandom_range(0, SHOW_CYC - 1)));
        run_round(2, int'($urandom_range(0, SHOW_CYC - 2)));
        // Key and hold in DONE are ignored
        key_valid = 1'b1;
        key_code  = 5'(m_tgt);
        step();
        key_valid = 1'b0;
        key_code  = 5'd16;
        step();
        done_check();

        // Game 2: four hits give a perfect score
        start_game();
        for (int r = 0; r < RN; r++) run_round(0, int'($urandom_range(0, SHOW_CYC - 1)));

        // Game 3: hit on the expiry edge, then reset during HIT
        start_game();
        for (int i = 0; i < SHOW_CYC - 1; i++) begin
            chk("late_hold", {24'd0, led}, 32'(1 << m_tgt));
            step();
        end
        key_valid = 1'b1;
        key_code  = 5'(m_tgt);
        step();
        key_valid = 1'b0;
        key_code  = 5'd16;
        chk("late_buzzer", {31'd0, buzzer}, 32'd1);
        chk("late_led", {24'd0, led}, 32'hFF);
        chk("late_score", {27'd0, score}, 32'd1);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("arst_buzzer", {31'd0, buzzer}, 32'd0);
        chk("arst_led", {24'd0, led}, 32'h00);
        chk("arst_score", {27'd0, score}, 32'd0);
        chk("arst_round", {27'd0, round}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        m_tgt = 0;
        prev_show_led = 8'h01;
        m_score = 0;
        m_round = 0;
        step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Randomized games, 104 consecutive rounds
        for (int g = 0; g < 26; g++) begin
            start_game();
            for (int r = 0; r < RN; r++)
                run_round(int'($urandom_range(0, 4)), int'($urandom_range(0, SHOW_CYC - 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mole_game_ctrl.md
MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): TICK_DIV, 100000, clk cycles per 1 ms tick (100 MHz clk).
REQ-002 SHOW_MS, 1000, mole display window in ticks; FEEDBACK_MS, 200, hit/miss feedback duration in ticks; ROUNDS, 16, rounds per game (1..31).
REQ-003 Ports SHALL be (name, direction, width, meaning): clk  in  1  system clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  single-cycle pulse; begins a game.
REQ-006 key_valid  in  1  single-cycle pulse from the debounced keypad scanner.
REQ-007 key_code  in  5  key index 0..15, or 16 for no key; sampled only when key_valid=1.
REQ-008 led  out  8  one-hot mole position, or feedback pattern.
REQ-009 buzzer  out  1  high during hit feedback.
REQ-010 score  out  5  hits in the current or last game.
REQ-011 round  out  5  completed rounds in the current game.
REQ-012 busy  out  1  high in SHOW, HIT and MISS.
REQ-013 done  out  1  high in DONE.
REQ-014 All outputs SHALL be registered.

Function
REQ-015 The FSM SHALL have states IDLE, SHOW, HIT, MISS, DONE.
REQ-016 IDLE: led=8'h00, buzzer=0. start -> SHOW; on this transition score=0 and round=0.
REQ-017 SHOW: led=1<<target. Transitions:
  - key_valid with key_code==target -> HIT; score+1 in the same edge.
  - key_valid with key_code in 0..7 and !=target -> MISS.
  - key_valid with key_code 8..16 -> ignored.
  - window expiry -> MISS.
REQ-018 HIT: led=8'hFF, buzzer=1. MISS: led=8'h00, buzzer=0.
REQ-019 On feedback expiry, round SHALL increment. If the new round==ROUNDS -> DONE; otherwise -> SHOW with a new target.
REQ-020 DONE: led=8'hFF if score==ROUNDS, else led=8'h00. done=1 and score holds. start -> SHOW with score=0 and round=0.
REQ-021 Timing:
  - A prescaler (0..TICK_DIV-1) and a tick counter SHALL both clear on every state entry.
  - SHOW dwell without a key SHALL be exactly SHOW_MS*TICK_DIV cycles.
  - HIT/MISS dwell SHALL be exactly FEEDBACK_MS*TICK_DIV cycles.
REQ-022 Latency: a key_valid sampled at edge t SHALL produce the new state, score and buzzer on the outputs after edge t.
REQ-023 A matching key and window expiry on the same edge SHALL resolve as HIT. A non-matching key and expiry on the same edge SHALL resolve as MISS.
REQ-024 start SHALL be ignored in SHOW, HIT and MISS. key_valid SHALL be ignored in IDLE, HIT, MISS and DONE.
REQ-025 Target generation:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5) SHALL advance every clk cycle.
  - On each SHOW entry, target = lfsr[2:0].
  - If that equals the previous target, target SHALL be (lfsr[2:0]+1) mod 8.
REQ-026 score and round SHALL saturate at ROUNDS and never wrap.

Reset
REQ-027 rst_n=0 SHALL immediately force:
  - state=IDLE
  - led=8'h00, buzzer=0
  - score=0, round=0
  - busy=0, done=0
  - prescaler and tick counter=0
  - lfsr=8'hA5
  - previous target=0
  This SHALL apply in any state, including mid-round.
REQ-028 After reset deassertion, the block SHALL remain in IDLE until start.

Verification (TICK_DIV=4, SHOW_MS=3, FEEDBACK_MS=2, ROUNDS=4)
REQ-029 Reset, then a start pulse -> busy=1 next edge. led is one-hot and stays stable for exactly 12 cycles, then MISS with led=8'h00 for 8 cycles, then round=1.
REQ-030 In SHOW, key_valid with key_code=target -> next edge: buzzer=1, led=8'hFF, score=1. buzzer stays high exactly 8 cycles.
REQ-031 Key pulses in SHOW:
  - key_code=16, then key_code=12 -> no state change.
  - key_code=(target+1)%8 -> MISS, score unchanged.
REQ-032 Four correct hits -> DONE with done=1, score=4, round=4, led=8'hFF. A further start pulse -> score=0, round=0, busy=1.
REQ-033 Matching key_valid on the same edge as window expiry -> HIT with score+1. rst_n pulsed low during HIT -> buzzer=0 and IDLE immediately, score=0.
REQ-034 Over 100 consecutive rounds, no two successive targets SHALL be equal.
